// File: rtl/sr_control.sv
// -----------------------------------------------------------------------------
// sr_control
//   Serial-load controller for a chip configuration shift register.
//
//   A rising edge on start captures the WIDTH-bit word on din into a shadow
//   register. The word is then shifted out on din_sr at one bit per clock.
//   After the final bit, load_sr pulses for one clock so the chip latches the
//   data. A transaction takes WIDTH+1 clocks from the start edge to load_sr
//   falling. Start edges that arrive while a transaction is running are dropped.
//
//   Build option (macro SR_LSB_FIRST_EN):
//     undefined : bits are serialized MSB first (default)
//     defined   : bits are serialized LSB first
//   Counts and load_sr timing are the same in both builds.
//
// Parameters:
//   WIDTH   configuration bits per transaction, 1..255 (fits the 8-bit count)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   din      in   [WIDTH] parallel configuration word, sampled on the start edge
//   start    in   transaction request, rising-edge detected
//   count    out  [8] bits presented on din_sr in the current or last transaction
//   din_sr   out  serial data to the chip shift register
//   load_sr  out  one-clock load strobe after the final bit
// -----------------------------------------------------------------------------
module sr_control #(
  parameter int WIDTH = 170
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  output logic [7:0]       count,
  output logic             din_sr,
  output logic             load_sr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;
  logic [WIDTH-1:0] shadow_shifted;
  logic             start_q;
  logic             start_edge;
  logic [7:0]       count_nxt;
  logic             din_sr_nxt;
  logic             load_sr_nxt;
  logic             capture_bit;

  assign start_edge = start & ~start_q;

  // The next serial bit is selected by shifting it down to bit 0. This avoids
  // a variable-width index into the shadow word.
`ifdef SR_LSB_FIRST_EN
  assign shadow_shifted = shadow >> count;
  assign capture_bit    = din[0];
`else
  assign shadow_shifted = shadow >> (8'(WIDTH - 1) - count);
  assign capture_bit    = din[WIDTH-1];
`endif

  // Next-state and registered-output logic
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_nxt   = state;
    shadow_nxt  = shadow;
    count_nxt   = count;
    din_sr_nxt  = 1'b0;
    load_sr_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_edge) begin
          shadow_nxt = din;
          din_sr_nxt = capture_bit;
          count_nxt  = 8'd1;
          state_nxt  = SHIFT;
        end
      end

      SHIFT: begin
        if (count < 8'(WIDTH)) begin
          din_sr_nxt = shadow_shifted[0];
          count_nxt  = count + 8'd1;
        end else begin
          // All WIDTH bits are out. Strobe load for one clock. The count holds
          // at WIDTH until the next transaction starts.
          load_sr_nxt = 1'b1;
          state_nxt   = LOAD;
        end
      end

      LOAD: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      // NOTE: the shadow word is reset as well. The wide flop bank then never
      // holds an undefined value before the first capture.
      shadow  <= '0;
      start_q <= 1'b0;
      count   <= 8'd0;
      din_sr  <= 1'b0;
      load_sr <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together from
      // the values present before the edge.
      state   <= state_nxt;
      shadow  <= shadow_nxt;
      start_q <= start;
      count   <= count_nxt;
      din_sr  <= din_sr_nxt;
      load_sr <= load_sr_nxt;
    end
  end

endmodule

// File: tb/tb_sr_control.sv
// -----------------------------------------------------------------------------
// tb_sr_control
//   Self-checking bench for sr_control.
//
//   The behavioural model tracks each transaction as a clock offset from its
//   accepted start edge. On every falling clock edge, a compare process checks
//   the DUT outputs against that model. Directed transactions add hand-computed
//   literal checks. A second DUT instance with WIDTH=1 covers the one-bit case.
// -----------------------------------------------------------------------------
module tb_sr_control;

  localparam int W = 170;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         start = 1'b0;
  logic [7:0]   count;
  logic         din_sr;
  logic         load_sr;

  logic         din1 = 1'b0;
  logic         start1 = 1'b0;
  logic [7:0]   count1;
  logic         din_sr1;
  logic         load_sr1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_load  = 0;

  sr_control #(.WIDTH(W)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .start   (start),
    .count   (count),
    .din_sr  (din_sr),
    .load_sr (load_sr)
  );

  sr_control #(.WIDTH(1)) u_one (
    .clk     (clk),
    .rst     (rst),
    .din     (din1),
    .start   (start1),
    .count   (count1),
    .din_sr  (din_sr1),
    .load_sr (load_sr1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model.
  //   m_k    : clocks since the accepted start edge, or -1 when no transaction
  //            is running. Offsets 0..W-1 carry data and offset W is the load
  //            clock.
  //   m_cnt  : bits presented so far. It holds after completion.
  // ---------------------------------------------------------------------------
  int         m_k = -1;
  int         m_cnt = 0;
  logic       m_prev = 1'b0;
  logic [W-1:0] m_word = '0;
  int         nk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k    <= -1;
      m_cnt  <= 0;
      m_prev <= 1'b0;
      m_word <= '0;
    end else begin
      nk = m_k;
      if (m_k < 0) begin
        if (start && !m_prev) begin
          m_word <= din;
          nk = 0;
        end
      end else begin
        nk = m_k + 1;
        if (nk > W) nk = -1;
      end
      m_prev <= start;
      m_k    <= nk;
      if (nk >= 0) m_cnt <= (nk < W) ? nk + 1 : W;
    end
  end

  function automatic logic exp_bit(input int k);
    logic [W-1:0] tmp;
`ifdef SR_LSB_FIRST_EN
    tmp = m_word >> k;
`else
    tmp = m_word >> (W - 1 - k);
`endif
    return tmp[0];
  endfunction

  always @(negedge clk) begin
    logic exp_sr;
    exp_sr = (m_k >= 0 && m_k < W) ? exp_bit(m_k) : 1'b0;
    check("cyc_din_sr", {31'd0, din_sr}, {31'd0, exp_sr});
    check("cyc_load_sr", {31'd0, load_sr}, {31'd0, (m_k == W)});
    check("cyc_count", {24'd0, count}, m_cnt);
    if (load_sr === 1'b1) n_load++;
  end

  // ---------------------------------------------------------------------------
  // Directed transaction driver. Each run records n falling-edge samples.
  // Sample 0 is data clock 0, the clock right after the start edge.
  // ---------------------------------------------------------------------------
  logic       obs_sr[$];
  logic       obs_ld[$];
  logic [7:0] obs_cnt[$];

  task automatic transact(input logic [W-1:0] word, input int n, input bit hold,
                          input bit flip, input int restart_at, input int rst_at);
    obs_sr.delete();
    obs_ld.delete();
    obs_cnt.delete();
    @(negedge clk);
    #1;
    din   = word;
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs_sr.push_back(din_sr);
      obs_ld.push_back(load_sr);
      obs_cnt.push_back(count);
      #1;
      if (k == 0 && !hold) start = 1'b0;
      if (k == 0 && flip) din = '0;
      if (k == restart_at - 1) start = 1'b1;
      if (k == restart_at) start = 1'b0;
      if (k == rst_at) rst = 1'b0;
    end
    if (hold) start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat;
    int base;
    int ones;

    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst_count", {24'd0, count}, 0);
    check("rst_din_sr", {31'd0, din_sr}, 0);
    check("rst_load_sr", {31'd0, load_sr}, 0);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // WIDTH=1: one data clock, then load
    #1;
    din1   = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    check("w1_data_bit", {31'd0, din_sr1}, 1);
    check("w1_data_count", {24'd0, count1}, 1);
    check("w1_data_load", {31'd0, load_sr1}, 0);
    #1 start1 = 1'b0;
    @(negedge clk);
    check("w1_load_bit", {31'd0, din_sr1}, 0);
    check("w1_load_strobe", {31'd0, load_sr1}, 1);
    @(negedge clk);
    check("w1_after_load", {31'd0, load_sr1}, 0);
    check("w1_after_count", {24'd0, count1}, 1);

    // Pattern 1011 with a one-clock start pulse
    base = n_load;
    transact(W'(4'b1011), W + 2, 1'b0, 1'b0, -1, -1);
`ifdef SR_LSB_FIRST_EN
    check("t2_bit0", {31'd0, obs_sr[0]}, 1);
    check("t2_bit1", {31'd0, obs_sr[1]}, 1);
    check("t2_bit2", {31'd0, obs_sr[2]}, 0);
    check("t2_bit3", {31'd0, obs_sr[3]}, 1);
    check("t2_bit169", {31'd0, obs_sr[169]}, 0);
`else
    check("t2_bit0", {31'd0, obs_sr[0]}, 0);
    check("t2_bit165", {31'd0, obs_sr[165]}, 0);
    check("t2_bit166", {31'd0, obs_sr[166]}, 1);
    check("t2_bit167", {31'd0, obs_sr[167]}, 0);
    check("t2_bit168", {31'd0, obs_sr[168]}, 1);
    check("t2_bit169", {31'd0, obs_sr[169]}, 1);
`endif
    check("t2_load_169", {31'd0, obs_ld[169]}, 0);
    check("t2_load_170", {31'd0, obs_ld[170]}, 1);
    check("t2_load_171", {31'd0, obs_ld[171]}, 0);
    check("t2_count_first", {24'd0, obs_cnt[0]}, 1);
    check("t2_count_end", {24'd0, obs_cnt[171]}, W);
    check("t2_load_pulses", n_load - base, 1);

    // Asynchronous reset while idle
    @(negedge clk);
    check("t1_count_before", {24'd0, count}, W);
    #1 rst = 1'b0;
    #1;
    check("t1_async_count", {24'd0, count}, 0);
    check("t1_async_din_sr", {31'd0, din_sr}, 0);
    check("t1_async_load_sr", {31'd0, load_sr}, 0);
    #2 rst = 1'b1;

    // Start held high for 400 clocks, then a fresh rising edge
    base = n_load;
    transact(W'(8'hA5), 400, 1'b1, 1'b0, -1, -1);
    check("t3_load_170", {31'd0, obs_ld[170]}, 1);
    check("t3_held_pulses", n_load - base, 1);
    repeat (3) @(negedge clk);
    base = n_load;
    transact(W'(8'h3C), W + 2, 1'b0, 1'b0, -1, -1);
    check("t3_second_pulses", n_load - base, 1);
    check("t3_second_count", {24'd0, obs_cnt[171]}, W);

    // din changes after capture
    base = n_load;
    transact('1, W + 2, 1'b0, 1'b1, -1, -1);
    ones = 0;
    for (int k = 0; k < W; k++) if (obs_sr[k]) ones++;
    check("t4_all_ones", ones, W);
    check("t4_pulses", n_load - base, 1);

    // Second start pulse during data clock 50
    base = n_load;
    transact(W'(16'hBEEF), W + 2, 1'b0, 1'b0, 50, -1);
    check("t5_load_170", {31'd0, obs_ld[170]}, 1);
    check("t5_pulses", n_load - base, 1);

    // Reset at data clock 80, then a clean transaction
    base = n_load;
    transact(W'(16'hFFFF) << 100, W + 2, 1'b0, 1'b0, -1, 80);
    check("t6_din_sr_after", {31'd0, obs_sr[81]}, 0);
    check("t6_count_after", {24'd0, obs_cnt[81]}, 0);
    check("t6_pulses", n_load - base, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    pat = '0;
    pat[W-1] = 1'b1;
    pat[0]   = 1'b1;
    base = n_load;
    transact(pat, W + 2, 1'b0, 1'b0, -1, -1);
    check("t6_new_first", {31'd0, obs_sr[0]}, 1);
    check("t6_new_second", {31'd0, obs_sr[1]}, 0);
    check("t6_new_last", {31'd0, obs_sr[169]}, 1);
    check("t6_new_load", {31'd0, obs_ld[170]}, 1);
    check("t6_new_pulses", n_load - base, 1);
    check("t6_new_count", {24'd0, obs_cnt[171]}, W);

    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
